// File: rtl/muldiv_hilo.sv
// HI/LO multiply-divide unit: latches operands for an external combinational multiplier
// and runs a 32-step restoring signed divider, writing results into the HI/LO registers.
module muldiv_hilo #(
    parameter int MULT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        IDLE,
        MULT_WAIT,
        DIV_RUN,
        DIV_FIX,
        DONE
    } state_t;

    localparam logic [4:0] MULT_LAST = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LAST  = 5'd31;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] rem, quo, dvsr;
    logic        neg_q, neg_r, dz;
    logic        busy_nxt, done_nxt, div_zero_nxt;
    logic [31:0] rem_sh;
    logic [32:0] trial;

    // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
    assign rem_sh = {rem[30:0], quo[31]};
    assign trial  = {1'b0, rem_sh} - {1'b0, dvsr};

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_mult)     state_nxt = MULT_WAIT;
                else if (start_div) state_nxt = DIV_RUN;
            end
            MULT_WAIT: if (cnt == MULT_LAST) state_nxt = DONE;
            DIV_RUN: begin
                if (dz)                   state_nxt = DONE;
                else if (cnt == DIV_LAST) state_nxt = DIV_FIX;
            end
            DIV_FIX: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state and registered alongside it.
    always_comb begin
        busy_nxt     = (state_nxt != IDLE);
        done_nxt     = (state_nxt == DONE);
        div_zero_nxt = (state == DIV_RUN) && dz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            done     <= done_nxt;
            div_zero <= div_zero_nxt;
        end
    end

    // NOTE: every datapath register is reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            mult_a <= '0;
            mult_b <= '0;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    cnt <= '0;
                    if (start_mult || start_div) begin
                        mult_a <= op_a;
                        mult_b <= op_b;
                        rem    <= '0;
                        quo    <= op_a[31] ? -op_a : op_a;
                        dvsr   <= op_b[31] ? -op_b : op_b;
                        neg_q  <= op_a[31] ^ op_b[31];
                        neg_r  <= op_a[31];
                        dz     <= (op_b == 32'd0);
                    end
                end
                MULT_WAIT: begin
                    if (cnt == MULT_LAST) begin
                        hi <= mult_hi;
                        lo <= mult_lo;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV_RUN: begin
                    if (!dz) begin
                        rem <= trial[32] ? rem_sh : trial[31:0];
                        quo <= {quo[30:0], ~trial[32]};
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV_FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    lo <= neg_q ? -quo : quo;
                    hi <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule
